// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer.
// Drives the shared execute-stage ALU one iteration per clock.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic [1:0]      iOp,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult,
  output logic [4:0]      oAluControl,
  output logic [XLEN-1:0] oAluA,
  output logic [XLEN-1:0] oAluB,
  input  logic [XLEN-1:0] iAluResult
);

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam int CW = $clog2(ITERS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [1:0]      op;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] opb;

  logic            is_div;
  logic            carry;
  logic            ge;
  logic            last;
  logic [XLEN:0]   s;
  logic [XLEN-1:0] nacc;
  logic [XLEN-1:0] nsh;
  logic [XLEN-1:0] na;
  logic [XLEN-1:0] res;
  logic [XLEN-1:0] start_a;

  // acc is hi (multiply) or R (divide); sh is lo or Q; opb is M or D
  assign is_div = op[1];
  assign carry  = iAluResult < acc;
  assign s      = {acc, sh[XLEN-1]};
  assign ge     = s >= {1'b0, opb};
  assign last   = cnt == CW'(ITERS - 1);
  assign start_a = {{(XLEN-1){1'b0}}, iOp[1] & iA[XLEN-1]};

  always_comb begin
    nacc = acc;
    nsh  = sh;
    unique case (1'b1)
      is_div && ge: begin
        nacc = iAluResult;
        nsh  = {sh[XLEN-2:0], 1'b1};
      end
      is_div && !ge: begin
        nacc = s[XLEN-1:0];
        nsh  = {sh[XLEN-2:0], 1'b0};
      end
      !is_div && sh[0]: begin
        nacc = {carry, iAluResult[XLEN-1:1]};
        nsh  = {iAluResult[0], sh[XLEN-1:1]};
      end
      default: begin
        nacc = {1'b0, acc[XLEN-1:1]};
        nsh  = {acc[0], sh[XLEN-1:1]};
      end
    endcase
  end

  // Next ALU A operand: hi for multiply, low bits of the next s for divide
  assign na  = is_div ? {nacc[XLEN-2:0], nsh[XLEN-1]} : nacc;
  assign res = op[0] ? nacc : nsh;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= IDLE;
      op          <= '0;
      cnt         <= '0;
      acc         <= '0;
      sh          <= '0;
      opb         <= '0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oResult     <= '0;
      oAluControl <= ALU_ADD;
      oAluA       <= '0;
      oAluB       <= '0;
    end else begin
      case (state)
        IDLE: begin
          oDone <= 1'b0;
          if (iStart) begin
            state       <= RUN;
            op          <= iOp;
            cnt         <= '0;
            acc         <= '0;
            sh          <= iA;
            opb         <= iB;
            oBusy       <= 1'b1;
            oAluControl <= iOp[1] ? ALU_SUB : ALU_ADD;
            oAluA       <= start_a;
            oAluB       <= iB;
          end
        end
        RUN: begin
          acc   <= nacc;
          sh    <= nsh;
          cnt   <= cnt + 1'b1;
          oAluA <= na;
          if (last) begin
            state       <= DONE;
            oDone       <= 1'b1;
            oResult     <= res;
            oAluControl <= ALU_ADD;
            oAluA       <= '0;
            oAluB       <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          oDone <= 1'b0;
          oBusy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: 64-bit arithmetic reference,
// busy-countdown timing model and per-cycle output compare.
module tb_muldiv_sequencer;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iStart = 1'b0;
  logic [1:0]  iOp = 2'd0;
  logic [31:0] iA = '0;
  logic [31:0] iB = '0;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;
  logic [4:0]  oAluControl;
  logic [31:0] oAluA;
  logic [31:0] oAluB;
  logic [31:0] iAluResult;

  int tests = 0;
  int fails = 0;

  always #5 iCLK = ~iCLK;

  assign iAluResult = (oAluControl == ALU_SUB) ? oAluA - oAluB
                                               : oAluA + oAluB;

  muldiv_sequencer dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iStart(iStart),
    .iOp(iOp),
    .iA(iA),
    .iB(iB),
    .oBusy(oBusy),
    .oDone(oDone),
    .oResult(oResult),
    .oAluControl(oAluControl),
    .oAluA(oAluA),
    .oAluB(oAluB),
    .iAluResult(iAluResult)
  );

  function automatic logic [31:0] ref_op(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: busy cycles remaining after an accepted start (33 total)
  int          left = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_res = '0;
  logic        m_div = 1'b0;
  bit          armed = 1'b0;

  always @(posedge iCLK) begin
    if (iRST) begin
      left  <= 0;
      m_res <= '0;
      armed <= 1'b1;
    end else if (left == 0) begin
      if (iStart) begin
        left   <= 33;
        m_pend <= ref_op(iOp, iA, iB);
        m_div  <= iOp[1];
      end
    end else begin
      left <= left - 1;
      if (left == 2) m_res <= m_pend;
    end
  end

  always @(negedge iCLK) begin
    if (armed) begin
      chk("busy", 32'(oBusy), 32'(left != 0));
      chk("done", 32'(oDone), 32'(left == 1));
      chk("result", oResult, m_res);
      if (left > 1) begin
        chk("alu ctl run", 32'(oAluControl),
            32'(m_div ? ALU_SUB : ALU_ADD));
      end else begin
        chk("alu ctl idle", 32'(oAluControl), 32'(ALU_ADD));
        chk("alu a idle", oAluA, 32'd0);
        chk("alu b idle", oAluB, 32'd0);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    for (int n = 0; n < 40 && oBusy; n++) @(negedge iCLK);
    iOp = op;
    iA = a;
    iB = b;
    iStart = 1'b1;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    iA = $urandom;
    iB = $urandom;
    iOp = 2'($urandom);
  endtask

  task automatic wait_done(input string nm, input logic [31:0] exp,
                           input bit chk_busy);
    int busy;
    bit got;
    busy = 0;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge iCLK);
      if (oBusy) busy++;
      if (oDone) got = 1'b1;
    end
    chk({nm, " done seen"}, 32'(got), 32'd1);
    if (got) chk(nm, oResult, exp);
    if (chk_busy) chk({nm, " busy cycles"}, 32'(busy), 32'd33);
  endtask

  task automatic run_op(input string nm, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    issue(op, a, b);
    wait_done(nm, exp, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    @(negedge iCLK);
    chk("reset busy", 32'(oBusy), 32'd0);
    chk("reset done", 32'(oDone), 32'd0);
    chk("reset result", oResult, 32'd0);
    chk("reset alu ctl", 32'(oAluControl), 32'(ALU_ADD));

    issue(2'd0, 32'd7, 32'd6);
    wait_done("mul 7x6", 32'h0000_002A, 1'b1);
    run_op("mul ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("mulhu ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("divu 100/7", 2'd2, 32'd100, 32'd7, 32'd14);
    run_op("remu 100/7", 2'd3, 32'd100, 32'd7, 32'd2);
    run_op("divu msb/1", 2'd2, 32'h8000_0000, 32'd1, 32'h8000_0000);
    run_op("remu msb/1", 2'd3, 32'h8000_0000, 32'd1, 32'd0);
    run_op("divu by 0", 2'd2, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    run_op("remu by 0", 2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678);

    issue(2'd0, 32'd1000, 32'd1000);
    repeat (5) @(posedge iCLK);
    #1;
    iStart = 1'b1;
    iOp = 2'd2;
    iA = 32'd77;
    iB = 32'd3;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    wait_done("start ignored", 32'd1000000, 1'b0);

    issue(2'd2, 32'hDEAD_BEEF, 32'd13);
    repeat (10) @(posedge iCLK);
    #1;
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    @(negedge iCLK);
    chk("abort busy", 32'(oBusy), 32'd0);
    chk("abort result", oResult, 32'd0);
    chk("abort done", 32'(oDone), 32'd0);
    run_op("mul 3x5", 2'd0, 32'd3, 32'd5, 32'd15);

    run_op("divu 9/2", 2'd2, 32'd9, 32'd2, 32'd4);
    run_op("remu 9/2", 2'd3, 32'd9, 32'd2, 32'd1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      run_op("random", op, a, b, ref_op(op, a, b));
    end

    repeat (3) @(negedge iCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
